// File: rtl/tile_local_mux_pkg.sv
// Shared definitions for the tile local-port multiplexer.
//   CNT_W        : width of the statistics counters
//   egr_state_t  : egress (accelerators -> switch) arbitration states
//   ing_state_t  : ingress (switch -> accelerators) routing states
//   sat_inc()    : saturating increment used by both counters
package tile_local_mux_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        E_IDLE,
        E_LOCK
    } egr_state_t;

    typedef enum logic [1:0] {
        I_HEAD,
        I_ROUTE,
        I_DROP
    } ing_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/tile_local_mux_if.sv
// Stream bundle between the accelerator channels and the switch local port.
//   acc_in_*    : NCH egress sources (accelerators -> mux)
//   local_in_*  : single egress stream (mux -> switch local-in)
//   local_out_* : single ingress stream (switch local-out -> mux)
//   acc_out_*   : NCH ingress sinks (mux -> accelerators), data broadcast
// Modports:
//   slave  : the mux itself
//   master : the surrounding environment (switch + accelerators)
interface tile_local_mux_if #(
    parameter int BW  = 32,
    parameter int BWB = BW / 8,
    parameter int NCH = 4
);
    logic [NCH-1:0]     acc_in_TVALID;
    logic [NCH-1:0]     acc_in_TLAST;
    logic [NCH*BW-1:0]  acc_in_TDATA;
    logic [NCH*BWB-1:0] acc_in_TKEEP;
    logic [NCH-1:0]     acc_in_TREADY;

    logic               local_in_TVALID;
    logic [BW-1:0]      local_in_TDATA;
    logic [BWB-1:0]     local_in_TKEEP;
    logic               local_in_TLAST;
    logic               local_in_TREADY;

    logic               local_out_TVALID;
    logic [BW-1:0]      local_out_TDATA;
    logic [BWB-1:0]     local_out_TKEEP;
    logic               local_out_TLAST;
    logic               local_out_TREADY;

    logic [NCH-1:0]     acc_out_TVALID;
    logic [NCH-1:0]     acc_out_TLAST;
    logic [NCH*BW-1:0]  acc_out_TDATA;
    logic [NCH*BWB-1:0] acc_out_TKEEP;
    logic [NCH-1:0]     acc_out_TREADY;

    modport slave (
        input  acc_in_TVALID, acc_in_TLAST, acc_in_TDATA, acc_in_TKEEP,
        output acc_in_TREADY,
        output local_in_TVALID, local_in_TDATA, local_in_TKEEP, local_in_TLAST,
        input  local_in_TREADY,
        input  local_out_TVALID, local_out_TDATA, local_out_TKEEP, local_out_TLAST,
        output local_out_TREADY,
        output acc_out_TVALID, acc_out_TLAST, acc_out_TDATA, acc_out_TKEEP,
        input  acc_out_TREADY
    );

    modport master (
        output acc_in_TVALID, acc_in_TLAST, acc_in_TDATA, acc_in_TKEEP,
        input  acc_in_TREADY,
        input  local_in_TVALID, local_in_TDATA, local_in_TKEEP, local_in_TLAST,
        output local_in_TREADY,
        output local_out_TVALID, local_out_TDATA, local_out_TKEEP, local_out_TLAST,
        input  local_out_TREADY,
        input  acc_out_TVALID, acc_out_TLAST, acc_out_TDATA, acc_out_TKEEP,
        output acc_out_TREADY
    );

endinterface

// File: rtl/tile_local_mux_rr_arbiter.sv
// Combinational round-robin search.
//   req         in  NCH  request vector
//   rr_ptr      in  IW   first channel to consider
//   grant_oh    out NCH  one-hot grant
//   grant_idx   out IW   index of the granted channel
//   grant_valid out 1    some request was found
// The first request at or after rr_ptr wins, wrapping NCH-1 -> 0.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  rr_ptr,
    output logic [NCH-1:0] grant_oh,
    output logic [IW-1:0]  grant_idx,
    output logic           grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Walk from the farthest offset back to rr_ptr so the nearest
        // request is the last one written and therefore wins.
        for (int off = NCH - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (req[IW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tile_local_mux.sv
// Tile local-port multiplexer between NCH accelerator channels and one
// switch local port. No data is registered; only control state is.
//   clk_line          in   line clock
//   clk_line_rst_low  in   asynchronous active-low reset
//   bus               slave stream bundle (see tile_local_mux_if)
//   drop_cnt          out  ingress packets discarded for a bad channel
//   egr_pkt_cnt       out  egress packets forwarded to the switch
// Egress: round-robin packet arbitration, grant locked until TLAST.
// Ingress: channel decoded from the header beat, latched for the body;
// out-of-range channels are swallowed and counted.
module tile_local_mux
    import tile_local_mux_pkg::*;
#(
    parameter int BW     = 32,
    parameter int BWB    = BW / 8,
    parameter int NCH    = 4,
    parameter int CH_LSB = 24
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_low,
    tile_local_mux_if.slave  bus,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] egr_pkt_cnt
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    // One guard bit above the channel index so that codes >= NCH
    // (e.g. 4..7 for NCH=4) are seen and dropped instead of aliasing.
    localparam int FW = IW + 1;

    // ------------------------------------------------------------ egress
    egr_state_t       e_state_reg, e_state_next;
    logic [IW-1:0]    grant_reg, grant_next;
    logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0] egr_cnt_reg, egr_cnt_next;

    logic [NCH-1:0]   arb_oh;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [NCH-1:0]   lock_oh;
    logic [NCH-1:0]   sel_oh;
    logic [IW-1:0]    sel;
    logic             sel_valid;
    logic             e_accept;

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_rr_arbiter (
        .req         (bus.acc_in_TVALID),
        .rr_ptr      (rr_ptr_reg),
        .grant_oh    (arb_oh),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    for (genvar gi = 0; gi < NCH; gi++) begin : g_lock_oh
        assign lock_oh[gi] = (grant_reg == IW'(gi));
    end

    // While locked the held grant is used even if its source idles,
    // so a TVALID gap never hands the port to another channel.
    always_comb begin
        sel       = arb_idx;
        sel_valid = arb_valid;
        sel_oh    = arb_oh;
        if (e_state_reg == E_LOCK) begin
            sel       = grant_reg;
            sel_valid = 1'b1;
            sel_oh    = lock_oh;
        end
    end

    assign bus.local_in_TVALID = clk_line_rst_low & sel_valid & bus.acc_in_TVALID[sel];
    assign bus.local_in_TDATA  = bus.acc_in_TDATA[int'(sel)*BW +: BW];
    assign bus.local_in_TKEEP  = bus.acc_in_TKEEP[int'(sel)*BWB +: BWB];
    assign bus.local_in_TLAST  = bus.acc_in_TLAST[sel];
    assign bus.acc_in_TREADY   = sel_oh & {NCH{clk_line_rst_low & bus.local_in_TREADY}};

    assign e_accept = bus.local_in_TVALID & bus.local_in_TREADY;

    always_comb begin
        e_state_next = e_state_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        egr_cnt_next = egr_cnt_reg;
        if (e_accept) begin
            if (bus.local_in_TLAST) begin
                e_state_next = E_IDLE;
                rr_ptr_next  = (int'(sel) == NCH - 1) ? '0 : sel + IW'(1);
                egr_cnt_next = sat_inc(egr_cnt_reg);
            end else begin
                e_state_next = E_LOCK;
                grant_next   = sel;
            end
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            e_state_reg <= E_IDLE;
            grant_reg   <= '0;
            rr_ptr_reg  <= '0;
            egr_cnt_reg <= '0;
        end else begin
            e_state_reg <= e_state_next;
            grant_reg   <= grant_next;
            rr_ptr_reg  <= rr_ptr_next;
            egr_cnt_reg <= egr_cnt_next;
        end
    end

    assign egr_pkt_cnt = egr_cnt_reg;

    // ----------------------------------------------------------- ingress
    ing_state_t       i_state_reg, i_state_next;
    logic [IW-1:0]    ch_reg, ch_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

    logic [FW-1:0]    hdr_field;
    logic             hdr_ok;
    logic [IW-1:0]    route_ch;
    logic             route_en;
    logic             drop_mode;
    logic             i_accept;

    assign hdr_field = bus.local_out_TDATA[CH_LSB +: FW];
    assign hdr_ok    = (int'(hdr_field) < NCH);

    // In I_HEAD the channel comes straight from the beat, so the header
    // reaches its accelerator in the same cycle it appears.
    always_comb begin
        route_ch  = ch_reg;
        route_en  = 1'b0;
        drop_mode = 1'b0;
        case (i_state_reg)
            I_HEAD: begin
                if (hdr_ok) begin
                    route_ch = hdr_field[IW-1:0];
                    route_en = 1'b1;
                end else begin
                    drop_mode = 1'b1;
                end
            end
            I_ROUTE: route_en  = 1'b1;
            I_DROP:  drop_mode = 1'b1;
            default: drop_mode = 1'b0;
        endcase
    end

    assign bus.local_out_TREADY = clk_line_rst_low &
        (drop_mode | (route_en & bus.acc_out_TREADY[route_ch]));

    for (genvar gi = 0; gi < NCH; gi++) begin : g_acc_out
        assign bus.acc_out_TVALID[gi] = clk_line_rst_low & route_en &
            (route_ch == IW'(gi)) & bus.local_out_TVALID;
    end

    assign bus.acc_out_TDATA = {NCH{bus.local_out_TDATA}};
    assign bus.acc_out_TKEEP = {NCH{bus.local_out_TKEEP}};
    assign bus.acc_out_TLAST = {NCH{bus.local_out_TLAST}};

    assign i_accept = bus.local_out_TVALID & bus.local_out_TREADY;

    always_comb begin
        i_state_next  = i_state_reg;
        ch_next       = ch_reg;
        drop_cnt_next = drop_cnt_reg;
        if (i_accept) begin
            case (i_state_reg)
                I_HEAD: begin
                    if (!bus.local_out_TLAST) begin
                        i_state_next = hdr_ok ? I_ROUTE : I_DROP;
                        ch_next      = hdr_field[IW-1:0];
                    end else if (!hdr_ok) begin
                        drop_cnt_next = sat_inc(drop_cnt_reg);
                    end
                end
                I_ROUTE: begin
                    if (bus.local_out_TLAST) begin
                        i_state_next = I_HEAD;
                    end
                end
                I_DROP: begin
                    if (bus.local_out_TLAST) begin
                        i_state_next  = I_HEAD;
                        drop_cnt_next = sat_inc(drop_cnt_reg);
                    end
                end
                default: i_state_next = I_HEAD;
            endcase
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            i_state_reg  <= I_HEAD;
            ch_reg       <= '0;
            drop_cnt_reg <= '0;
        end else begin
            i_state_reg  <= i_state_next;
            ch_reg       <= ch_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign drop_cnt = drop_cnt_reg;

endmodule
